clock_12h_display_scan: RTL and testbench

//  Display-side consumer of the 12-hour timekeeper outputs (hours/minutes/seconds/am_pm).

---
 rtl/clock_disp_pkg.sv | 49 ++++
 rtl/seg7_decode.sv | 26 ++
 rtl/clock_12h_display_scan.sv | 144 ++++++++++++++
 tb/tb_clock_12h_display_scan.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the 12-hour clock display: segment patterns, slot map and BCD split.
// Segment bit order is {g,f,e,d,c,b,a}.
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] SLOT_HR_T  = 3'd0;
    localparam logic [2:0] SLOT_HR_U  = 3'd1;
    localparam logic [2:0] SLOT_MIN_T = 3'd2;
    localparam logic [2:0] SLOT_MIN_U = 3'd3;
    localparam logic [2:0] SLOT_SEC_T = 3'd4;
    localparam logic [2:0] SLOT_SEC_U = 3'd5;

    // Returns {tens, units}; compare chain avoids a general divider.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] base;
        if (v >= 6'd60) begin
            tens = 4'd6; base = 6'd60;
        end else if (v >= 6'd50) begin
            tens = 4'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1; base = 6'd10;
        end else begin
            tens = 4'd0; base = 6'd0;
        end
        return {tens, 4'(v - base)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        unique case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_12h_display_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment driver for a 12-hour timekeeper.
// Time is snapshotted once per frame so a frame never mixes two time values.
module clock_12h_display_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV         = 1000,
    parameter bit          SEG_ACTIVE_LOW   = 1'b0,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            hours,
    input  logic [5:0]            minutes,
    input  logic [5:0]            seconds,
    input  logic                  am_pm,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done,
    output logic                  time_err
);

    localparam int unsigned    PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_INV    = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [3:0]    r_hours;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_pm;
    logic          r_err;
    logic          r_frame_done;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [NUM_DIGITS-1:0] r_digit_en;

    logic                  w_presc_last;
    logic                  w_snap;
    logic                  w_in_err;
    logic [7:0]            w_hr_bcd;
    logic [7:0]            w_min_bcd;
    logic [7:0]            w_sec_bcd;
    logic [3:0]            w_digit;
    logic [6:0]            w_dec_seg;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_dig_en;

    assign w_presc_last = (r_presc == PRESC_LAST);
    assign w_snap       = w_presc_last && (r_idx == SLOT_SEC_U);
    assign w_in_err     = (hours == 4'd0) || (hours > 4'd12) ||
                          (minutes > 6'd59) || (seconds > 6'd59);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= SLOT_HR_T;
        end else if (w_presc_last) begin
            r_presc <= '0;
            r_idx   <= (r_idx == SLOT_SEC_U) ? SLOT_HR_T : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Reset snapshot is a valid 12:00:00 AM so the first frame is well defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hours      <= 4'd12;
            r_min        <= 6'd0;
            r_sec        <= 6'd0;
            r_pm         <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_snap;
            if (w_snap) begin
                r_hours <= hours;
                r_min   <= minutes;
                r_sec   <= seconds;
                r_pm    <= am_pm;
                r_err   <= w_in_err;
            end
        end
    end

    assign w_hr_bcd  = bin_to_bcd({2'b00, r_hours});
    assign w_min_bcd = bin_to_bcd(r_min);
    assign w_sec_bcd = bin_to_bcd(r_sec);

    always_comb begin
        w_digit = 4'd0;
        unique case (r_idx)
            SLOT_HR_T:  w_digit = w_hr_bcd[7:4];
            SLOT_HR_U:  w_digit = w_hr_bcd[3:0];
            SLOT_MIN_T: w_digit = w_min_bcd[7:4];
            SLOT_MIN_U: w_digit = w_min_bcd[3:0];
            SLOT_SEC_T: w_digit = w_sec_bcd[7:4];
            SLOT_SEC_U: w_digit = w_sec_bcd[3:0];
            default:    w_digit = 4'd0;
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Error overrides everything, including leading-zero blanking and the PM dot.
    always_comb begin
        w_seg    = w_dec_seg;
        w_dp     = (r_idx == SLOT_SEC_U) && r_pm;
        w_dig_en = NUM_DIGITS'(1) << r_idx;
        if (r_err) begin
            w_seg = SEG_DASH;
            w_dp  = 1'b0;
        end else if ((r_idx == SLOT_HR_T) && blank_lz && (w_hr_bcd[7:4] == 4'd0)) begin
            w_seg = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= SEG_INV;
            r_dp       <= SEG_ACTIVE_LOW;
            r_digit_en <= DIG_INV;
        end else begin
            r_seg      <= w_seg ^ SEG_INV;
            r_dp       <= w_dp ^ SEG_ACTIVE_LOW;
            r_digit_en <= w_dig_en ^ DIG_INV;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;
    assign time_err   = r_err;

endmodule

// File: tb/tb_clock_12h_display_scan.sv
// Directed bench: active-high and fully inverted builds run side by side with SCAN_DIV=4.
module tb_clock_12h_display_scan;

    localparam logic [0:5][5:0] DE_SCAN   = {6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    localparam logic [0:5][6:0] F_1200    = {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [0:5][6:0] F_0307_B  = {7'h00, 7'h4F, 7'h3F, 7'h07, 7'h66, 7'h6D};
    localparam logic [0:5][6:0] F_1159    = {7'h06, 7'h06, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
    localparam logic [0:5][6:0] F_0905    = {7'h3F, 7'h6F, 7'h3F, 7'h6D, 7'h3F, 7'h3F};
    localparam logic [0:5][6:0] F_0905_B  = {7'h00, 7'h6F, 7'h3F, 7'h6D, 7'h3F, 7'h3F};
    localparam logic [0:5][6:0] F_DASH    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    logic       clk;
    logic       rst_n;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       blank_lz;
    logic [6:0] seg,   n_seg;
    logic       dp,    n_dp;
    logic [5:0] digit_en, n_digit_en;
    logic       frame_done, n_frame_done;
    logic       time_err,   n_time_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:5][6:0] f_seg;
    logic [0:5]      f_dp;
    logic [0:5][5:0] f_de;
    int              f_fd_cnt;

    clock_12h_display_scan #(
        .SCAN_DIV         (4),
        .SEG_ACTIVE_LOW   (1'b0),
        .DIGIT_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .am_pm      (am_pm),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .digit_en   (digit_en),
        .frame_done (frame_done),
        .time_err   (time_err)
    );

    clock_12h_display_scan #(
        .SCAN_DIV         (4),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut_n (
        .clk        (clk),
        .rst_n      (rst_n),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .am_pm      (am_pm),
        .blank_lz   (blank_lz),
        .seg        (n_seg),
        .dp         (n_dp),
        .digit_en   (n_digit_en),
        .frame_done (n_frame_done),
        .time_err   (n_time_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic pm);
        hours = h; minutes = m; seconds = s; am_pm = pm;
    endtask

    // Records the first cycle of each slot; must start one cycle before the first slot.
    task automatic grab_slots(input int first, input int last);
        for (int s = first; s <= last; s++) begin
            tick;
            f_seg[s] = seg;
            f_dp[s]  = dp;
            f_de[s]  = digit_en;
            f_fd_cnt += int'(frame_done);
            for (int k = 0; k < 3; k++) begin
                tick;
                f_fd_cnt += int'(frame_done);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_time(4'd3, 6'd7, 6'd45, 1'b1);
        blank_lz = 1'b1;
        repeat (3) tick;
        n_tests++;
        if ({seg, dp, digit_en, frame_done, time_err} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_active_high: got seg=%h dp=%b de=%b fd=%b err=%b want all 0",
                     seg, dp, digit_en, frame_done, time_err);
        end
        n_tests++;
        if ({n_seg, n_dp, n_digit_en} !== {7'h7F, 1'b1, 6'h3F}) begin
            n_fail++;
            $display("FAIL reset_active_low: got seg=%h dp=%b de=%h want 7f 1 3f",
                     n_seg, n_dp, n_digit_en);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (digit_en !== 6'h00) begin
            n_fail++;
            $display("FAIL release_no_edge_de: got %b want 000000", digit_en);
        end
        f_fd_cnt = 0;
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_1200 || f_dp !== 6'b000000 || f_de !== DE_SCAN) begin
            n_fail++;
            $display("FAIL reset_frame1: got seg=%h dp=%b de=%h want seg=%h dp=000000 de=%h",
                     f_seg, f_dp, f_de, F_1200, DE_SCAN);
        end
        n_tests++;
        if (f_fd_cnt != 1 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame1_done: got count=%0d last=%b want 1 1", f_fd_cnt, frame_done);
        end
        f_fd_cnt = 0;
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_0307_B || f_dp !== 6'b000001 || f_de !== DE_SCAN) begin
            n_fail++;
            $display("FAIL frame2_0307pm: got seg=%h dp=%b de=%h want seg=%h dp=000001",
                     f_seg, f_dp, f_de, F_0307_B);
        end
        n_tests++;
        if (f_fd_cnt != 1 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame2_done_period: got count=%0d last=%b want 1 1",
                     f_fd_cnt, frame_done);
        end
    endtask

    task automatic test_snapshot_mid_frame;
        set_time(4'd11, 6'd59, 6'd59, 1'b0);
        grab_slots(0, 5);
        grab_slots(0, 2);
        set_time(4'd12, 6'd0, 6'd0, 1'b1);
        grab_slots(3, 5);
        n_tests++;
        if (f_seg !== F_1159 || f_dp !== 6'b000000) begin
            n_fail++;
            $display("FAIL mid_frame_hold: got seg=%h dp=%b want seg=%h dp=000000",
                     f_seg, f_dp, F_1159);
        end
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_1200 || f_dp !== 6'b000001) begin
            n_fail++;
            $display("FAIL next_frame_1200pm: got seg=%h dp=%b want seg=%h dp=000001",
                     f_seg, f_dp, F_1200);
        end
    endtask

    task automatic test_leading_zero;
        set_time(4'd9, 6'd5, 6'd0, 1'b0);
        blank_lz = 1'b0;
        grab_slots(0, 5);
        grab_slots(0, 2);
        blank_lz = 1'b1;
        grab_slots(3, 5);
        n_tests++;
        if (f_seg !== F_0905 || f_dp !== 6'b000000 || f_de !== DE_SCAN) begin
            n_fail++;
            $display("FAIL lz_off_0905: got seg=%h dp=%b de=%h want seg=%h",
                     f_seg, f_dp, f_de, F_0905);
        end
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_0905_B || f_de !== DE_SCAN) begin
            n_fail++;
            $display("FAIL lz_on_0905: got seg=%h de=%h want seg=%h de=%h",
                     f_seg, f_de, F_0905_B, DE_SCAN);
        end
    endtask

    task automatic test_time_err;
        set_time(4'd0, 6'd0, 6'd0, 1'b1);
        grab_slots(0, 5);
        n_tests++;
        if (time_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_hours0_flag: got %b want 1", time_err);
        end
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_DASH || f_dp !== 6'b000000) begin
            n_fail++;
            $display("FAIL err_hours0_frame: got seg=%h dp=%b want seg=%h dp=000000",
                     f_seg, f_dp, F_DASH);
        end
        set_time(4'd12, 6'd60, 6'd0, 1'b1);
        grab_slots(0, 5);
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_DASH || f_dp !== 6'b000000 || time_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_min60: got seg=%h dp=%b err=%b want seg=%h dp=000000 err=1",
                     f_seg, f_dp, time_err, F_DASH);
        end
        set_time(4'd12, 6'd0, 6'd0, 1'b1);
        grab_slots(0, 5);
        n_tests++;
        if (time_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b want 0", time_err);
        end
        grab_slots(0, 5);
        n_tests++;
        if (f_seg !== F_1200 || f_dp !== 6'b000001) begin
            n_fail++;
            $display("FAIL err_recover_frame: got seg=%h dp=%b want seg=%h dp=000001",
                     f_seg, f_dp, F_1200);
        end
    endtask

    task automatic test_polarity;
        int bad;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            tick;
            if (n_seg !== ~seg || n_dp !== ~dp || n_digit_en !== ~digit_en ||
                n_frame_done !== frame_done || n_time_err !== time_err) begin
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL polarity_inverse: got %0d differing cycles want 0", bad);
        end
    endtask

    task automatic test_async_reset;
        grab_slots(0, 2);
        tick;
        n_tests++;
        if (digit_en !== 6'h08) begin
            n_fail++;
            $display("FAIL async_slot3_pos: got %b want 001000", digit_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({seg, dp, digit_en, frame_done, time_err} !== 16'h0 ||
            {n_seg, n_dp, n_digit_en} !== {7'h7F, 1'b1, 6'h3F}) begin
            n_fail++;
            $display("FAIL async_reset_now: got seg=%h dp=%b de=%b nseg=%h ndp=%b nde=%h",
                     seg, dp, digit_en, n_seg, n_dp, n_digit_en);
        end
        tick;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (digit_en !== 6'h00) begin
            n_fail++;
            $display("FAIL async_release_de: got %b want 000000", digit_en);
        end
        grab_slots(0, 5);
        n_tests++;
        if (f_de[0] !== 6'h01 || f_seg !== F_1200 || f_dp !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_restart_frame: got de0=%b seg=%h dp=%b want 000001 %h 000000",
                     f_de[0], f_seg, f_dp, F_1200);
        end
    endtask

    initial begin
        test_reset;
        test_snapshot_mid_frame;
        test_leading_zero;
        test_time_err;
        test_polarity;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
